bram_be: RTL

Parametrised simple-dual-port block RAM for the matrixmul datapath. It is the successor to the single-byte BRAM:
- configurable data width with per-byte write enables;
- fully posedge-synchronous read with a `rd_valid` strobe;
- optional hardware clear of the whole array after reset, with a `ready` flag;
- compile-time selectable read-during-write forwarding.

It holds operand and result matrices between the load engine and the MAC array.

---
 rtl/bram_be.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bram_be.sv
// Simple-dual-port block RAM with byte-lane write enables, registered read and
// optional post-reset zero sweep. Define BRAM_FWD_EN for write-first same-address reads.
module bram_be #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             ready,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            dout,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            din
);

  // state    | meaning
  // ST_CLEAR | sweeping zeros through the array, one word per cycle
  // ST_READY | normal read/write service, left only through reset

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic                    r_ready;
  logic                    r_rd_valid;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic                    w_clr_wr;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [NB-1:0]           w_mem_be;
  logic [DATA_WIDTH-1:0]   w_mem_din;
  logic [DATA_WIDTH-1:0]   w_rd_old;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: r_ready <= 1'b1;
        default:  r_state <= ST_CLEAR;
      endcase
    end
  end

  // User requests are only honoured once the registered ready flag is up.
  always_comb begin
    w_acc_rd   = r_ready & rd_en;
    w_acc_wr   = r_ready & wr_en & ~reset;
    w_clr_wr   = (r_state == ST_CLEAR) & ~reset;
    w_mem_we   = w_clr_wr | w_acc_wr;
    w_mem_addr = w_clr_wr ? r_clr_addr : wr_addr;
    w_mem_be   = w_clr_wr ? {NB{1'b1}} : wr_be;
    w_mem_din  = w_clr_wr ? '0 : din;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_we && w_mem_be[i])
        r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign w_rd_old = r_mem[rd_addr];

`ifdef BRAM_FWD_EN
  // Write-first: enabled lanes of a same-address write bypass the array.
  always_comb begin
    w_rd_word = w_rd_old;
    if (w_acc_wr && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i])
          w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
`else
  assign w_rd_word = w_rd_old;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_rd_valid <= w_acc_rd;
      if (w_acc_rd)
        r_dout <= w_rd_word;
    end
  end

  assign ready    = r_ready;
  assign rd_valid = r_rd_valid;
  assign dout     = r_dout;

endmodule
